// File: rtl/sram_write_scheduler.sv
// sram_write_scheduler
// Drains the per-queue input FIFOs into the shared SRAM write channel.
// Round-robin arbitration between eligible queues, bounded bursts, one
// outstanding FIFO read at a time, per-queue ring write pointer and an
// occupancy level that the read side decrements through q_release.
module sram_write_scheduler #(
    parameter int NUM_QUEUES     = 4,
    parameter int QUEUE_ID_WIDTH = 2,
    parameter int MEM_ADDR_WIDTH = 19,
    parameter int PTR_WIDTH      = MEM_ADDR_WIDTH - QUEUE_ID_WIDTH,
    parameter int QUEUE_SIZE     = 1 << PTR_WIDTH,
    parameter int DATA_WIDTH     = 201,
    parameter int BURST_LEN      = 4
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 cal_done,
    input  logic [NUM_QUEUES-1:0]                q_empty,
    input  logic [NUM_QUEUES-1:0]                q_valid,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0]     q_dout,
    output logic [NUM_QUEUES-1:0]                q_rinc,
    output logic                                 mem_wr_en,
    output logic [MEM_ADDR_WIDTH-1:0]            mem_wr_addr,
    output logic [DATA_WIDTH-1:0]                mem_wr_data,
    input  logic                                 mem_wr_ready,
    input  logic [NUM_QUEUES-1:0]                q_release,
    output logic [NUM_QUEUES*PTR_WIDTH-1:0]      q_wr_ptr,
    output logic [NUM_QUEUES*(PTR_WIDTH+1)-1:0]  q_level,
    output logic                                 level_err
);

    localparam int LVL_W = PTR_WIDTH + 1;
    localparam logic [LVL_W-1:0] QSIZE_L = LVL_W'(QUEUE_SIZE);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ARB   = 3'd1;
    localparam logic [2:0] READ  = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] WRITE = 3'd4;

    logic [2:0]                r_state;
    logic [QUEUE_ID_WIDTH-1:0] r_grant;
    logic [QUEUE_ID_WIDTH-1:0] r_rr_last;
    logic [3:0]                r_burst_cnt;
    logic [DATA_WIDTH-1:0]     r_data;
    logic [PTR_WIDTH-1:0]      r_wr_ptr [NUM_QUEUES];
    logic [LVL_W-1:0]          r_level  [NUM_QUEUES];
    logic                      r_level_err;

    logic [NUM_QUEUES-1:0]     w_elig;
    logic                      w_found;
    logic [QUEUE_ID_WIDTH-1:0] w_pick;
    logic                      w_accept;
    logic                      w_cont;
    logic [LVL_W-1:0]          w_level_next [NUM_QUEUES];
    logic [NUM_QUEUES-1:0]     w_err_set;

    assign w_accept = (r_state == WRITE) && mem_wr_ready;

    // A queue may be granted only when memory is calibrated, its FIFO has data and its region is not full
    always_comb begin
        for (int i = 0; i < NUM_QUEUES; i++) begin
            w_elig[i] = cal_done && !q_empty[i] && (r_level[i] < QSIZE_L);
        end
    end

    // Round-robin search starting just after the last granted queue
    always_comb begin
        logic [QUEUE_ID_WIDTH-1:0] v_idx;
        w_found = 1'b0;
        w_pick  = '0;
        v_idx   = '0;
        for (int k = 1; k <= NUM_QUEUES; k++) begin
            v_idx = QUEUE_ID_WIDTH'((int'(r_rr_last) + k) % NUM_QUEUES);
            if (!w_found && w_elig[v_idx]) begin
                w_found = 1'b1;
                w_pick  = v_idx;
            end
        end
    end

    // Next occupancy per queue: an accepted write and a release in the same cycle cancel out
    always_comb begin
        for (int i = 0; i < NUM_QUEUES; i++) begin
            w_level_next[i] = r_level[i];
            w_err_set[i]    = 1'b0;
            if (w_accept && (r_grant == QUEUE_ID_WIDTH'(i)) && !q_release[i]) begin
                w_level_next[i] = r_level[i] + 1'b1;
            end else if (q_release[i] && !(w_accept && (r_grant == QUEUE_ID_WIDTH'(i)))) begin
                if (r_level[i] == '0) begin
                    w_err_set[i] = 1'b1;
                end else begin
                    w_level_next[i] = r_level[i] - 1'b1;
                end
            end
        end
    end

    // The burst continues only if budget remains and the granted queue is still eligible after this write
    always_comb begin
        w_cont = (({1'b0, r_burst_cnt} + 5'd1) < 5'(BURST_LEN))
               && cal_done
               && !q_empty[r_grant]
               && (w_level_next[r_grant] < QSIZE_L);
    end

    // Scheduler FSM: arbitrate, strobe the FIFO, capture its word, present it until the SRAM accepts
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_rr_last   <= QUEUE_ID_WIDTH'(NUM_QUEUES - 1);
            r_burst_cnt <= '0;
            r_data      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cal_done) r_state <= ARB;
                end
                ARB: begin
                    if (w_found) begin
                        r_grant     <= w_pick;
                        r_rr_last   <= w_pick;
                        r_burst_cnt <= '0;
                        r_state     <= READ;
                    end
                end
                READ: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (q_valid[r_grant]) begin
                        r_data  <= q_dout[r_grant*DATA_WIDTH +: DATA_WIDTH];
                        r_state <= WRITE;
                    end
                end
                WRITE: begin
                    if (mem_wr_ready) begin
                        r_burst_cnt <= r_burst_cnt + 4'd1;
                        r_state     <= w_cont ? READ : ARB;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Per-queue ring pointers advance on each accepted write; levels track writes against releases
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_QUEUES; i++) begin
                r_wr_ptr[i] <= '0;
                r_level[i]  <= '0;
            end
            r_level_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_QUEUES; i++) begin
                r_level[i] <= w_level_next[i];
                if (w_accept && (r_grant == QUEUE_ID_WIDTH'(i))) begin
                    r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
                end
            end
            r_level_err <= r_level_err | (|w_err_set);
        end
    end

    // Output decode: read strobe only in READ, write channel driven only in WRITE
    always_comb begin
        q_rinc = '0;
        if (r_state == READ) q_rinc[r_grant] = 1'b1;
        mem_wr_en   = (r_state == WRITE);
        mem_wr_addr = mem_wr_en ? {r_grant, r_wr_ptr[r_grant]} : '0;
        mem_wr_data = r_data;
        level_err   = r_level_err;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            q_wr_ptr[i*PTR_WIDTH +: PTR_WIDTH] = r_wr_ptr[i];
            q_level[i*LVL_W +: LVL_W]          = r_level[i];
        end
    end

endmodule

// File: tb/tb_sram_write_scheduler.sv
// tb_sram_write_scheduler
// Directed bench: FIFO and SRAM models around the scheduler, hand-computed
// expected addresses, data, cycle spacing and occupancy values.
// Address width is reduced to 7 bits (32-word regions) so that the ring wrap
// and the full-region condition are reachable in a short run.
module tb_sram_write_scheduler;

    localparam int NQ = 4;
    localparam int QW = 2;
    localparam int AW = 7;
    localparam int PW = AW - QW;
    localparam int LW = PW + 1;
    localparam int QS = 1 << PW;
    localparam int DW = 201;
    localparam int BL = 4;

    logic                 clk;
    logic                 resetn;
    logic                 cal_done;
    logic [NQ-1:0]        q_empty;
    logic [NQ-1:0]        q_valid;
    logic [NQ*DW-1:0]     q_dout;
    logic [NQ-1:0]        q_rinc;
    logic                 mem_wr_en;
    logic [AW-1:0]        mem_wr_addr;
    logic [DW-1:0]        mem_wr_data;
    logic                 mem_wr_ready;
    logic [NQ-1:0]        q_release;
    logic [NQ*PW-1:0]     q_wr_ptr;
    logic [NQ*LW-1:0]     q_level;
    logic                 level_err;

    sram_write_scheduler #(
        .NUM_QUEUES(NQ), .QUEUE_ID_WIDTH(QW), .MEM_ADDR_WIDTH(AW),
        .PTR_WIDTH(PW), .QUEUE_SIZE(QS), .DATA_WIDTH(DW), .BURST_LEN(BL)
    ) dut (
        .clk(clk), .resetn(resetn), .cal_done(cal_done),
        .q_empty(q_empty), .q_valid(q_valid), .q_dout(q_dout), .q_rinc(q_rinc),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_ready(mem_wr_ready), .q_release(q_release),
        .q_wr_ptr(q_wr_ptr), .q_level(q_level), .level_err(level_err)
    );

    int checks = 0;
    int passes = 0;

    logic [DW-1:0] fifoMem [NQ][64];
    int            fifoHead [NQ];
    int            fifoTail [NQ];

    int            cycle = 0;
    int            logCount = 0;
    logic [AW-1:0] logAddr [256];
    logic [DW-1:0] logData [256];
    int            logCycle [256];
    int            rincCount = 0;
    int            rincViol = 0;
    logic          outstanding = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: read data valid one cycle after the read strobe
    always @(posedge clk) begin
        for (int i = 0; i < NQ; i++) begin
            q_valid[i] <= 1'b0;
            if (q_rinc[i] && (fifoTail[i] != fifoHead[i])) begin
                q_dout[i*DW +: DW] <= fifoMem[i][fifoHead[i] % 64];
                q_valid[i]         <= 1'b1;
                fifoHead[i]        <= fifoHead[i] + 1;
            end
        end
    end

    // Empty flags settle mid-cycle so the DUT sees them stable at the edge
    always @(negedge clk) begin
        for (int i = 0; i < NQ; i++) q_empty[i] <= (fifoTail[i] == fifoHead[i]);
    end

    // SRAM model and read-strobe monitor
    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (resetn && mem_wr_en && mem_wr_ready) begin
            logAddr[logCount]  <= mem_wr_addr;
            logData[logCount]  <= mem_wr_data;
            logCycle[logCount] <= cycle;
            logCount           <= logCount + 1;
        end
        if (!resetn) begin
            outstanding <= 1'b0;
        end else if (q_rinc != '0) begin
            rincCount <= rincCount + 1;
            if (outstanding || !$onehot(q_rinc)) rincViol <= rincViol + 1;
            outstanding <= 1'b1;
        end else if (mem_wr_en && mem_wr_ready) begin
            outstanding <= 1'b0;
        end
    end

    function automatic logic [DW-1:0] makeWord(input int q, input int idx);
        return {8'(q), 8'(idx), 185'(32'hA5000000 ^ (q * 1000 + idx * 17))};
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        else passes++;
    endtask

    task automatic applyStimulus(input int q, input int firstIdx, input int n);
        for (int k = 0; k < n; k++) begin
            fifoMem[q][fifoTail[q] % 64] = makeWord(q, firstIdx + k);
            fifoTail[q]++;
        end
    endtask

    task automatic applyReset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic waitWrites(input int n, input int budget);
        int c = 0;
        while (logCount < n && c < budget) begin
            @(posedge clk); #1; c++;
        end
        if (logCount < n) checkOutput("writeTimeout", 256'(logCount), 256'(n));
    endtask

    task automatic waitEnable(input int budget);
        int c = 0;
        while (!mem_wr_en && c < budget) begin
            @(posedge clk); #1; c++;
        end
        if (!mem_wr_en) checkOutput("enableTimeout", 0, 1);
    endtask

    // Directed test sequence
    initial begin
        int base;
        int rc;
        int qs [3];
        int e;
        qs = '{0, 1, 3};
        for (int i = 0; i < NQ; i++) begin
            fifoHead[i] = 0;
            fifoTail[i] = 0;
        end
        resetn = 1'b0; cal_done = 1'b1; q_release = '0; mem_wr_ready = 1'b1;

        // Reset state with all queues empty
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_wr_en", 256'(mem_wr_en), 0);
        checkOutput("rst_addr", 256'(mem_wr_addr), 0);
        checkOutput("rst_data", 256'(mem_wr_data), 0);
        checkOutput("rst_rinc", 256'(q_rinc), 0);
        checkOutput("rst_ptrs", 256'(q_wr_ptr), 0);
        checkOutput("rst_levels", 256'(q_level), 0);
        checkOutput("rst_err", 256'(level_err), 0);
        resetn = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("idle_rinc", 256'(rincCount), 0);
        checkOutput("idle_wr_en", 256'(mem_wr_en), 0);

        // Queue 2 alone, six words: 4-word burst, ARB cycle, 2-word burst
        base = logCount;
        applyStimulus(2, 0, 6);
        waitWrites(base + 6, 100);
        for (int k = 0; k < 6; k++) begin
            checkOutput("q2_addr", 256'(logAddr[base+k]), 256'(2 * QS + k));
            checkOutput("q2_data", 256'(logData[base+k]), 256'(makeWord(2, k)));
            if (k > 0) checkOutput("q2_gap", 256'(logCycle[base+k] - logCycle[base+k-1]), (k == 4) ? 256'd4 : 256'd3);
        end
        @(posedge clk); #1;
        checkOutput("q2_level", 256'(q_level[2*LW +: LW]), 6);
        checkOutput("q2_ptr", 256'(q_wr_ptr[2*PW +: PW]), 6);

        // Three queues, eight words each: round-robin 0,1,3,0,1,3
        applyReset();
        base = logCount;
        for (int j = 0; j < 3; j++) applyStimulus(qs[j], 0, 8);
        waitWrites(base + 24, 200);
        for (int b = 0; b < 2; b++)
            for (int j = 0; j < 3; j++)
                for (int k = 0; k < BL; k++) begin
                    e = base + b * 12 + j * 4 + k;
                    checkOutput("rr_addr", 256'(logAddr[e]), 256'(qs[j] * QS + b * 4 + k));
                    checkOutput("rr_data", 256'(logData[e]), 256'(makeWord(qs[j], b * 4 + k)));
                end
        @(posedge clk); #1;
        checkOutput("rr_levels", 256'(q_level), 256'({6'd8, 6'd0, 6'd8, 6'd8}));

        // Back-pressure: write held stable while ready is low
        applyReset();
        mem_wr_ready = 1'b0;
        base = logCount;
        applyStimulus(0, 0, 2);
        waitEnable(20);
        rc = rincCount;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            checkOutput("stall_en", 256'(mem_wr_en), 1);
            checkOutput("stall_addr", 256'(mem_wr_addr), 0);
            checkOutput("stall_data", 256'(mem_wr_data), 256'(makeWord(0, 0)));
        end
        checkOutput("stall_rinc", 256'(rincCount), 256'(rc));
        checkOutput("stall_level", 256'(q_level[0 +: LW]), 0);
        mem_wr_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("stall_accepts", 256'(logCount), 256'(base + 1));
        checkOutput("stall_level1", 256'(q_level[0 +: LW]), 1);
        checkOutput("stall_ptr1", 256'(q_wr_ptr[0 +: PW]), 1);
        waitWrites(base + 2, 20);
        checkOutput("stall_addr2", 256'(logAddr[base+1]), 1);
        @(posedge clk); #1;
        checkOutput("stall_level2", 256'(q_level[0 +: LW]), 2);

        // Ring wrap on queue 1 and full-region blocking
        applyReset();
        base = logCount;
        applyStimulus(1, 0, QS - 1);
        waitWrites(base + QS - 1, 250);
        @(posedge clk); #1;
        checkOutput("wrap_ptr31", 256'(q_wr_ptr[PW +: PW]), 256'(QS - 1));
        applyStimulus(1, QS - 1, 2);
        waitWrites(base + QS, 30);
        checkOutput("wrap_addr_top", 256'(logAddr[base+QS-1]), 256'(QS + QS - 1));
        checkOutput("wrap_data_top", 256'(logData[base+QS-1]), 256'(makeWord(1, QS - 1)));
        repeat (10) @(posedge clk);
        #1;
        checkOutput("full_no_write", 256'(logCount), 256'(base + QS));
        checkOutput("full_level", 256'(q_level[LW +: LW]), 256'(QS));
        checkOutput("full_ptr0", 256'(q_wr_ptr[PW +: PW]), 0);
        q_release[1] = 1'b1;
        @(posedge clk); #1;
        q_release[1] = 1'b0;
        waitWrites(base + QS + 1, 30);
        checkOutput("wrap_addr0", 256'(logAddr[base+QS]), 256'(QS));
        checkOutput("wrap_data0", 256'(logData[base+QS]), 256'(makeWord(1, QS)));
        @(posedge clk); #1;
        checkOutput("wrap_level", 256'(q_level[LW +: LW]), 256'(QS));

        // Release at level zero, and simultaneous accept plus release
        applyReset();
        q_release[0] = 1'b1;
        @(posedge clk); #1;
        q_release[0] = 1'b0;
        checkOutput("err_level0", 256'(q_level[0 +: LW]), 0);
        checkOutput("err_set", 256'(level_err), 1);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("err_sticky", 256'(level_err), 1);
        base = logCount;
        applyStimulus(3, 0, 1);
        waitWrites(base + 1, 20);
        mem_wr_ready = 1'b0;
        applyStimulus(3, 1, 1);
        waitEnable(20);
        mem_wr_ready = 1'b1;
        q_release[3] = 1'b1;
        @(posedge clk); #1;
        q_release[3] = 1'b0;
        checkOutput("both_accept", 256'(logCount), 256'(base + 2));
        checkOutput("both_level", 256'(q_level[3*LW +: LW]), 1);
        checkOutput("both_ptr", 256'(q_wr_ptr[3*PW +: PW]), 2);

        // Reset while a write is pending drops the request and the word
        mem_wr_ready = 1'b0;
        applyStimulus(2, 9, 1);
        waitEnable(20);
        resetn = 1'b0;
        @(posedge clk); #1;
        checkOutput("rstw_en", 256'(mem_wr_en), 0);
        checkOutput("rstw_data", 256'(mem_wr_data), 0);
        checkOutput("rstw_err", 256'(level_err), 0);
        resetn = 1'b1;
        mem_wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        checkOutput("single_outstanding_read", 256'(rincViol), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
